wb_crossbar: RTL and testbench
==============================

# wb_crossbar

Parametrised Wishbone B4 (classic, non-pipelined) crossbar connecting NM masters to NS slaves with concurrent master-to-slave paths. Each slave has its own round-robin arbiter; a master's address is decoded against per-slave base/mask pairs. Unmapped accesses and slaves that never acknowledge are terminated with a bus error. It is the successor to the fixed shared interconnect and sits between the CPU/DMA masters and the peripheral/memory slaves.

## Interface
- NM, 2, number of masters (1..8)
- NS, 2, number of slaves (1..8)
- AW, 32, address width
- DW, 32, data width; SW = DW/8 select width
- SBASE, {NS{AW'h0}}, per-slave base address array
- SMASK, {NS{AW'h0}}, per-slave decode mask array; hit when (adr & SMASK[s]) == SBASE[s]
- TIMEOUT, 255, max cycles a strobed slave may withhold ack; 0 disables
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- madr_i/mdat_i  in  [NM] x AW/DW  master address / write data
- mwe_i, mstb_i, mcyc_i  in  [NM] x 1  master write enable, strobe, cycle
- msel_i  in  [NM] x SW  master byte selects
- mdat_o  out  [NM] x DW  read data to master
- mack_o, merr_o  out  [NM] x 1  ack / error to master
- sadr_o/sdat_o  out  [NS] x AW/DW  slave address / write data
- swe_o, sstb_o, scyc_o  out  [NS] x 1  to slave
- ssel_o  out  [NS] x SW  byte selects to slave
- sdat_i, sack_i  in  [NS] x DW / 1  from slave

## Operation
- Decode: master m targets the lowest-index slave s that hits. No hit → unmapped.
- Request: m requests s when mcyc_i[m] & mstb_i[m] and m decodes to s and m owns no slave.
- Ownership: grant[s] register (owner index plus valid). Held while the owner's mcyc_i stays high. While m owns s, m's decode is ignored, and all of m's strobes go to s. A master owns at most one slave.
- Arbitration per slave when free, or on the edge the owner drops mcyc_i:
  - Search starts at (last[s]+1) mod NM; first requester wins; last[s] updated.
  - Handover needs no idle cycle.
- Routing: an owned slave gets the owner's adr/dat/we/sel/stb/cyc. A free slave gets all zeros.
- Return path: the owner gets sdat_i/sack_i of its slave. A non-owning master gets mdat_o=0, mack_o=0.
- Unmapped access: error responder registers merr_o=1 the cycle after the strobe, for one cycle. It re-pulses every other cycle while mstb_i stays high. mack_o stays 0.
- Timeout: per-slave counter increments each cycle sstb_o[s]=1 and sack_i[s]=0, and clears on ack or when stb falls.
  - When the count reaches TIMEOUT: merr_o to the owner for one cycle, counter cleared, slave strobe forced low that cycle.
  - Ownership is kept until mcyc_i falls.
- merr_o and mack_o are never high together; a timeout has priority over a coincident late ack, which is dropped.
- Reset (async, any time): grants invalid, last[s]=NM-1 (so master 0 wins first), counters 0, error flags 0. All outputs go to 0 immediately. In-flight cycles are abandoned.

## Timing
- Cycle 0: master asserts cyc/stb. Edge end of cycle 0: grant registered.
- Cycle 1: scyc_o/sstb_o high.
- sack_i → mack_o and sdat_i → mdat_o are combinational (same cycle).
- Minimum single transfer: 2 cycles. Back-to-back strobes within a held cycle: 1 cycle each for a zero-wait slave.
- Unmapped access: merr_o in cycle 1.
- Timeout: merr_o in the cycle the count reaches TIMEOUT, i.e. cycle 1+TIMEOUT after first slave strobe.
- Counter width: $clog2(TIMEOUT+1).

## Structure
- Package wb_pkg: master-side and slave-side request/response struct typedefs, a clog2-based index width helper.
- Sub-module wb_rr_arbiter (NM-wide request vector, hold, grant index/valid, last pointer); instantiated NS times.
- Decode, error responder and timeout counters stay in the top module.

## Test plan
- Reset mid-transfer: rst_i pulse while m0 owns s1 → all outputs 0 asynchronously. After release, m0 read completes normally.
- Single read: SBASE={0x0000_0000,0x1000_0000}, SMASK=0xF000_0000. m0 reads 0x1000_0004; s1 acks in cycle 2 with 0xDEADBEEF → scyc_o[1]/sstb_o[1] from cycle 1, mack_o[0] and mdat_o[0]=0xDEADBEEF in cycle 2, s0 untouched.
- Contention: m0 and m1 both request s0 in cycle 0 after reset → m0 granted. When m0 drops cyc, m1 is granted on the same edge. The next simultaneous request goes to m0 (round-robin alternates).
- Concurrency: m0→s0 and m1→s1 in the same cycle → both granted in cycle 1; both complete independently.
- Unmapped: SMASK=0xF000_0000, m1 writes 0x5000_0000 → merr_o[1]=1 in cycle 1 only, no slave strobed, mack_o[1]=0.
- Timeout: TIMEOUT=4, s0 never acks → merr_o[0] pulses one cycle at cycle 5 with sstb_o[0] low that cycle. After m0 drops cyc, s0 is free.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone B4 classic crossbar.
package wb_pkg;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic cyc;
    logic stb;
    logic we;
  } wb_req_ctl_t;

  typedef struct packed {
    logic ack;
    logic err;
  } wb_rsp_t;

  typedef enum logic {
    ERR_IDLE  = 1'b0,
    ERR_PULSE = 1'b1
  } err_state_t;

endpackage

// File: rtl/wb_crossbar_if.sv
// Bundled master-side and slave-side Wishbone signals of the crossbar.
interface wb_crossbar_if #(
  parameter int unsigned NM = 2,
  parameter int unsigned NS = 2,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW = DW / 8;

  logic [NM-1:0][AW-1:0] madr_i;
  logic [NM-1:0][DW-1:0] mdat_i;
  logic [NM-1:0]         mwe_i;
  logic [NM-1:0]         mstb_i;
  logic [NM-1:0]         mcyc_i;
  logic [NM-1:0][SW-1:0] msel_i;
  logic [NM-1:0][DW-1:0] mdat_o;
  logic [NM-1:0]         mack_o;
  logic [NM-1:0]         merr_o;

  logic [NS-1:0][AW-1:0] sadr_o;
  logic [NS-1:0][DW-1:0] sdat_o;
  logic [NS-1:0]         swe_o;
  logic [NS-1:0]         sstb_o;
  logic [NS-1:0]         scyc_o;
  logic [NS-1:0][SW-1:0] ssel_o;
  logic [NS-1:0][DW-1:0] sdat_i;
  logic [NS-1:0]         sack_i;

  modport xbar (
    input  madr_i, mdat_i, mwe_i, mstb_i, mcyc_i, msel_i, sdat_i, sack_i,
    output mdat_o, mack_o, merr_o, sadr_o, sdat_o, swe_o, sstb_o, scyc_o, ssel_o
  );

  modport master (
    output madr_i, mdat_i, mwe_i, mstb_i, mcyc_i, msel_i,
    input  mdat_o, mack_o, merr_o
  );

  modport slave (
    input  sadr_o, sdat_o, swe_o, sstb_o, scyc_o, ssel_o,
    output sdat_i, sack_i
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Per-slave round-robin arbiter: holds the grant while the owner keeps cyc,
// otherwise picks the first requester after the last winner.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned NM = 2,
  localparam int unsigned IW = idx_w(NM)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [NM-1:0] req,
  input  logic          hold,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] last;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;

  // Two passes: indices above last first, then wrap to those at or below it.
  always_comb begin
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (!pick_valid && req[i] && (i > 32'(last))) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(i);
      end
    end
    for (int unsigned i = 0; i < NM; i++) begin
      if (!pick_valid && req[i] && (i <= 32'(last))) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      last        <= IW'(NM - 1);
    end else if (!hold) begin
      grant_valid <= pick_valid;
      if (pick_valid) begin
        grant_idx <= pick_idx;
        last      <= pick_idx;
      end
    end
  end

endmodule

// File: rtl/wb_crossbar.sv
// Wishbone B4 classic crossbar: NM masters to NS slaves, per-slave round-robin
// arbitration, bus error for unmapped accesses and for slaves that never ack.
module wb_crossbar
  import wb_pkg::*;
#(
  parameter int unsigned            NM      = 2,
  parameter int unsigned            NS      = 2,
  parameter int unsigned            AW      = 32,
  parameter int unsigned            DW      = 32,
  parameter logic [NS-1:0][AW-1:0]  SBASE   = '0,
  parameter logic [NS-1:0][AW-1:0]  SMASK   = '0,
  parameter int unsigned            TIMEOUT = 255
) (
  input logic         clk_i,
  input logic         rst_i,
  wb_crossbar_if.xbar bus
);

  localparam int unsigned MI = idx_w(NM);
  localparam int unsigned SI = idx_w(NS);
  localparam int unsigned TW = idx_w(TIMEOUT + 1);

  logic [NM-1:0]          dec_hit;
  logic [NM-1:0][SI-1:0]  dec_idx;
  logic [NS-1:0]          gnt_valid;
  logic [NS-1:0][MI-1:0]  gnt_idx;
  logic [NM-1:0]          owns;
  logic [NM-1:0][SI-1:0]  own_slv;
  logic [NS-1:0][NM-1:0]  req;
  logic [NM-1:0]          unmapped;
  logic [NS-1:0]          hold;
  logic [NS-1:0]          sstb_raw;
  logic [NS-1:0]          to_hit;
  logic [NS-1:0][TW-1:0]  tcnt;
  logic [NM-1:0]          to_err;
  err_state_t             err_q [NM];
  err_state_t             err_d [NM];
  wb_req_ctl_t [NS-1:0]   sctl;
  wb_rsp_t     [NM-1:0]   mrsp;

  // Descending scan so the lowest-index hitting slave is the one kept.
  always_comb begin
    dec_hit = '0;
    dec_idx = '0;
    for (int unsigned m = 0; m < NM; m++) begin
      for (int unsigned s = NS; s > 0; s--) begin
        if ((bus.madr_i[m] & SMASK[s-1]) == SBASE[s-1]) begin
          dec_hit[m] = 1'b1;
          dec_idx[m] = SI'(s - 1);
        end
      end
    end
  end

  always_comb begin
    owns    = '0;
    own_slv = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      for (int unsigned m = 0; m < NM; m++) begin
        if (gnt_valid[s] && (gnt_idx[s] == MI'(m))) begin
          owns[m]    = 1'b1;
          own_slv[m] = SI'(s);
        end
      end
    end
  end

  always_comb begin
    req      = '0;
    unmapped = '0;
    for (int unsigned m = 0; m < NM; m++) begin
      if (bus.mcyc_i[m] && bus.mstb_i[m] && !owns[m]) begin
        if (dec_hit[m]) req[dec_idx[m]][m] = 1'b1;
        else            unmapped[m] = 1'b1;
      end
    end
  end

  always_comb begin
    hold     = '0;
    sstb_raw = '0;
    to_hit   = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      if (gnt_valid[s]) begin
        hold[s]     = bus.mcyc_i[gnt_idx[s]];
        sstb_raw[s] = bus.mstb_i[gnt_idx[s]];
      end
      to_hit[s] = (TIMEOUT != 0) && sstb_raw[s] && (tcnt[s] == TW'(TIMEOUT));
    end
  end

  for (genvar s = 0; s < NS; s++) begin : g_arb
    wb_rr_arbiter #(.NM(NM)) u_arb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req         (req[s]),
      .hold        (hold[s]),
      .grant_idx   (gnt_idx[s]),
      .grant_valid (gnt_valid[s])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tcnt <= '0;
    end else begin
      for (int unsigned s = 0; s < NS; s++) begin
        if ((TIMEOUT == 0) || to_hit[s] || !sstb_raw[s] || bus.sack_i[s])
          tcnt[s] <= '0;
        else
          tcnt[s] <= tcnt[s] + TW'(1);
      end
    end
  end

  // Unmapped responder alternates pulse/idle while the strobe is held.
  always_comb begin
    for (int unsigned m = 0; m < NM; m++) begin
      err_d[m] = (unmapped[m] && (err_q[m] == ERR_IDLE)) ? ERR_PULSE : ERR_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned m = 0; m < NM; m++) err_q[m] <= ERR_IDLE;
    end else begin
      for (int unsigned m = 0; m < NM; m++) err_q[m] <= err_d[m];
    end
  end

  always_comb begin
    sctl       = '0;
    bus.sadr_o = '0;
    bus.sdat_o = '0;
    bus.ssel_o = '0;
    bus.scyc_o = '0;
    bus.sstb_o = '0;
    bus.swe_o  = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      if (gnt_valid[s]) begin
        sctl[s].cyc   = bus.mcyc_i[gnt_idx[s]];
        sctl[s].stb   = sstb_raw[s] && !to_hit[s];
        sctl[s].we    = bus.mwe_i[gnt_idx[s]];
        bus.sadr_o[s] = bus.madr_i[gnt_idx[s]];
        bus.sdat_o[s] = bus.mdat_i[gnt_idx[s]];
        bus.ssel_o[s] = bus.msel_i[gnt_idx[s]];
      end
      bus.scyc_o[s] = sctl[s].cyc;
      bus.sstb_o[s] = sctl[s].stb;
      bus.swe_o[s]  = sctl[s].we;
    end
  end

  // Error wins over ack: a late ack coinciding with a timeout is dropped.
  always_comb begin
    to_err     = '0;
    mrsp       = '0;
    bus.mdat_o = '0;
    bus.mack_o = '0;
    bus.merr_o = '0;
    for (int unsigned m = 0; m < NM; m++) begin
      for (int unsigned s = 0; s < NS; s++) begin
        if (to_hit[s] && (gnt_idx[s] == MI'(m))) to_err[m] = 1'b1;
      end
      mrsp[m].err = (err_q[m] == ERR_PULSE) || to_err[m];
      if (owns[m]) begin
        mrsp[m].ack   = bus.sack_i[own_slv[m]] && !to_hit[own_slv[m]] && !mrsp[m].err;
        bus.mdat_o[m] = bus.sdat_i[own_slv[m]];
      end
      bus.mack_o[m] = mrsp[m].ack;
      bus.merr_o[m] = mrsp[m].err;
    end
  end

endmodule

// File: tb/tb_wb_crossbar.sv
// Directed bench for wb_crossbar: 2 masters, 2 slaves, TIMEOUT=4.
module tb_wb_crossbar;

  localparam int unsigned NM = 2;
  localparam int unsigned NS = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_crossbar_if #(.NM(NM), .NS(NS), .AW(AW), .DW(DW)) bus ();

  wb_crossbar #(
    .NM      (NM),
    .NS      (NS),
    .AW      (AW),
    .DW      (DW),
    .SBASE   ({32'h1000_0000, 32'h0000_0000}),
    .SMASK   ({32'hF000_0000, 32'hF000_0000}),
    .TIMEOUT (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.madr_i = '0;
    bus.mdat_i = '0;
    bus.mwe_i  = '0;
    bus.mstb_i = '0;
    bus.mcyc_i = '0;
    bus.msel_i = '0;
    bus.sdat_i = '0;
    bus.sack_i = '0;
  endtask

  task automatic idle();
    clear_inputs();
    step();
    step();
  endtask

  task automatic drive_m(input int m, input logic [31:0] adr, input logic we, input logic [31:0] dat);
    bus.madr_i[m] = adr;
    bus.mdat_i[m] = dat;
    bus.mwe_i[m]  = we;
    bus.msel_i[m] = 4'hF;
    bus.mcyc_i[m] = 1'b1;
    bus.mstb_i[m] = 1'b1;
  endtask

  task automatic drop_m(input int m);
    bus.mcyc_i[m] = 1'b0;
    bus.mstb_i[m] = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #12;
    checks++; if (bus.scyc_o !== 2'b00) begin errors++; $display("FAIL reset_scyc: got %b exp 00", bus.scyc_o); end
    checks++; if (bus.mack_o !== 2'b00 || bus.merr_o !== 2'b00) begin errors++; $display("FAIL reset_resp: got ack %b err %b exp 00/00", bus.mack_o, bus.merr_o); end
    rst = 1'b0;
    step();
    drive_m(0, 32'h1000_0008, 1'b0, 32'h0);
    step();
    checks++; if (bus.scyc_o !== 2'b10) begin errors++; $display("FAIL pre_reset_grant: got %b exp 10", bus.scyc_o); end
    bus.sack_i[1] = 1'b1;
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.scyc_o !== 2'b00 || bus.sstb_o !== 2'b00) begin errors++; $display("FAIL async_reset_slave: got cyc %b stb %b exp 00/00", bus.scyc_o, bus.sstb_o); end
    checks++; if (bus.mack_o !== 2'b00) begin errors++; $display("FAIL async_reset_ack: got %b exp 00", bus.mack_o); end
    bus.sack_i[1] = 1'b0;
    rst = 1'b0;
    step();
    checks++; if (bus.scyc_o !== 2'b10) begin errors++; $display("FAIL post_reset_grant: got %b exp 10", bus.scyc_o); end
    bus.sack_i[1] = 1'b1;
    bus.sdat_i[1] = 32'h1234_5678;
    #1;
    checks++; if (bus.mack_o !== 2'b01 || bus.mdat_o[0] !== 32'h1234_5678) begin errors++; $display("FAIL post_reset_read: got ack %b dat %h exp 01/12345678", bus.mack_o, bus.mdat_o[0]); end
    idle();
  endtask

  task automatic test_single_read();
    drive_m(0, 32'h1000_0004, 1'b0, 32'h0);
    #1;
    checks++; if (bus.scyc_o !== 2'b00) begin errors++; $display("FAIL read_c0_scyc: got %b exp 00", bus.scyc_o); end
    step();
    checks++; if (bus.scyc_o !== 2'b10 || bus.sstb_o !== 2'b10) begin errors++; $display("FAIL read_c1_strobe: got cyc %b stb %b exp 10/10", bus.scyc_o, bus.sstb_o); end
    checks++; if (bus.sadr_o[1] !== 32'h1000_0004 || bus.sadr_o[0] !== 32'h0) begin errors++; $display("FAIL read_c1_adr: got s1 %h s0 %h exp 10000004/0", bus.sadr_o[1], bus.sadr_o[0]); end
    checks++; if (bus.mack_o !== 2'b00) begin errors++; $display("FAIL read_c1_ack: got %b exp 00", bus.mack_o); end
    step();
    bus.sack_i[1] = 1'b1;
    bus.sdat_i[1] = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.mack_o !== 2'b01 || bus.mdat_o[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_c2_data: got ack %b dat %h exp 01/deadbeef", bus.mack_o, bus.mdat_o[0]); end
    checks++; if (bus.mdat_o[1] !== 32'h0 || bus.merr_o !== 2'b00) begin errors++; $display("FAIL read_c2_other: got dat1 %h err %b exp 0/00", bus.mdat_o[1], bus.merr_o); end
    idle();
  endtask

  task automatic test_contention();
    rst = 1'b1;
    #1 rst = 1'b0;
    drive_m(0, 32'h0000_0010, 1'b0, 32'h0);
    drive_m(1, 32'h0000_0020, 1'b0, 32'h0);
    step();
    checks++; if (bus.sadr_o[0] !== 32'h0000_0010 || bus.scyc_o[0] !== 1'b1) begin errors++; $display("FAIL cont_first: got adr %h cyc %b exp 00000010/1", bus.sadr_o[0], bus.scyc_o[0]); end
    bus.sack_i[0] = 1'b1;
    #1;
    checks++; if (bus.mack_o !== 2'b01) begin errors++; $display("FAIL cont_first_ack: got %b exp 01", bus.mack_o); end
    step();
    bus.sack_i[0] = 1'b0;
    drop_m(0);
    step();
    checks++; if (bus.sadr_o[0] !== 32'h0000_0020 || bus.scyc_o[0] !== 1'b1) begin errors++; $display("FAIL cont_handover: got adr %h cyc %b exp 00000020/1", bus.sadr_o[0], bus.scyc_o[0]); end
    bus.sack_i[0] = 1'b1;
    #1;
    checks++; if (bus.mack_o !== 2'b10) begin errors++; $display("FAIL cont_handover_ack: got %b exp 10", bus.mack_o); end
    idle();
    drive_m(0, 32'h0000_0010, 1'b0, 32'h0);
    drive_m(1, 32'h0000_0020, 1'b0, 32'h0);
    step();
    checks++; if (bus.sadr_o[0] !== 32'h0000_0010) begin errors++; $display("FAIL cont_rr_m0: got %h exp 00000010", bus.sadr_o[0]); end
    idle();
    drive_m(0, 32'h0000_0010, 1'b0, 32'h0);
    drive_m(1, 32'h0000_0020, 1'b0, 32'h0);
    step();
    checks++; if (bus.sadr_o[0] !== 32'h0000_0020) begin errors++; $display("FAIL cont_rr_m1: got %h exp 00000020", bus.sadr_o[0]); end
    idle();
  endtask

  task automatic test_concurrency();
    drive_m(0, 32'h0000_0100, 1'b0, 32'h0);
    drive_m(1, 32'h1000_0200, 1'b1, 32'hCAFE_F00D);
    step();
    checks++; if (bus.scyc_o !== 2'b11 || bus.sstb_o !== 2'b11) begin errors++; $display("FAIL conc_both: got cyc %b stb %b exp 11/11", bus.scyc_o, bus.sstb_o); end
    checks++; if (bus.sadr_o[0] !== 32'h0000_0100 || bus.sadr_o[1] !== 32'h1000_0200) begin errors++; $display("FAIL conc_adr: got %h %h exp 00000100 10000200", bus.sadr_o[0], bus.sadr_o[1]); end
    checks++; if (bus.swe_o !== 2'b10 || bus.sdat_o[1] !== 32'hCAFE_F00D || bus.ssel_o[1] !== 4'hF) begin errors++; $display("FAIL conc_write: got we %b dat %h sel %h exp 10/cafef00d/f", bus.swe_o, bus.sdat_o[1], bus.ssel_o[1]); end
    bus.sack_i    = 2'b11;
    bus.sdat_i[0] = 32'hAAAA_0000;
    bus.sdat_i[1] = 32'hBBBB_1111;
    #1;
    checks++; if (bus.mack_o !== 2'b11 || bus.mdat_o[0] !== 32'hAAAA_0000 || bus.mdat_o[1] !== 32'hBBBB_1111) begin errors++; $display("FAIL conc_ack: got ack %b dat %h %h exp 11/aaaa0000/bbbb1111", bus.mack_o, bus.mdat_o[0], bus.mdat_o[1]); end
    idle();
  endtask

  task automatic test_back_to_back();
    drive_m(0, 32'h0000_0004, 1'b0, 32'h0);
    step();
    bus.sack_i[0] = 1'b1;
    bus.sdat_i[0] = 32'h1111_0000;
    #1;
    checks++; if (bus.mack_o[0] !== 1'b1 || bus.mdat_o[0] !== 32'h1111_0000) begin errors++; $display("FAIL b2b_first: got ack %b dat %h exp 1/11110000", bus.mack_o[0], bus.mdat_o[0]); end
    step();
    bus.madr_i[0] = 32'h0000_0008;
    bus.sdat_i[0] = 32'h2222_0000;
    #1;
    checks++; if (bus.sadr_o[0] !== 32'h0000_0008 || bus.mack_o[0] !== 1'b1 || bus.mdat_o[0] !== 32'h2222_0000) begin errors++; $display("FAIL b2b_second: got adr %h ack %b dat %h exp 00000008/1/22220000", bus.sadr_o[0], bus.mack_o[0], bus.mdat_o[0]); end
    idle();
  endtask

  task automatic test_unmapped();
    drive_m(1, 32'h5000_0000, 1'b1, 32'h0);
    #1;
    checks++; if (bus.merr_o !== 2'b00) begin errors++; $display("FAIL unm_c0: got %b exp 00", bus.merr_o); end
    step();
    checks++; if (bus.merr_o !== 2'b10 || bus.mack_o !== 2'b00 || bus.sstb_o !== 2'b00) begin errors++; $display("FAIL unm_c1: got err %b ack %b stb %b exp 10/00/00", bus.merr_o, bus.mack_o, bus.sstb_o); end
    drop_m(1);
    step();
    checks++; if (bus.merr_o !== 2'b00) begin errors++; $display("FAIL unm_c2: got %b exp 00", bus.merr_o); end
    idle();
    drive_m(1, 32'h5000_0000, 1'b0, 32'h0);
    step();
    checks++; if (bus.merr_o[1] !== 1'b1) begin errors++; $display("FAIL unm_hold_c1: got %b exp 1", bus.merr_o[1]); end
    step();
    checks++; if (bus.merr_o[1] !== 1'b0) begin errors++; $display("FAIL unm_hold_c2: got %b exp 0", bus.merr_o[1]); end
    step();
    checks++; if (bus.merr_o[1] !== 1'b1) begin errors++; $display("FAIL unm_hold_c3: got %b exp 1", bus.merr_o[1]); end
    drop_m(1);
    step();
    checks++; if (bus.merr_o[1] !== 1'b0) begin errors++; $display("FAIL unm_hold_c4: got %b exp 0", bus.merr_o[1]); end
    idle();
  endtask

  task automatic test_timeout();
    drive_m(0, 32'h0000_0040, 1'b0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (bus.sstb_o[0] !== 1'b1 || bus.merr_o[0] !== 1'b0) begin errors++; $display("FAIL to_wait_c%0d: got stb %b err %b exp 1/0", i, bus.sstb_o[0], bus.merr_o[0]); end
    end
    step();
    bus.sack_i[0] = 1'b1;
    #1;
    checks++; if (bus.merr_o[0] !== 1'b1 || bus.mack_o[0] !== 1'b0 || bus.sstb_o[0] !== 1'b0) begin errors++; $display("FAIL to_c5: got err %b ack %b stb %b exp 1/0/0", bus.merr_o[0], bus.mack_o[0], bus.sstb_o[0]); end
    step();
    bus.sack_i[0] = 1'b0;
    #1;
    checks++; if (bus.merr_o[0] !== 1'b0 || bus.sstb_o[0] !== 1'b1) begin errors++; $display("FAIL to_c6: got err %b stb %b exp 0/1", bus.merr_o[0], bus.sstb_o[0]); end
    drop_m(0);
    drive_m(1, 32'h0000_0080, 1'b0, 32'h0);
    step();
    checks++; if (bus.sadr_o[0] !== 32'h0000_0080 || bus.sstb_o[0] !== 1'b1 || bus.merr_o !== 2'b00) begin errors++; $display("FAIL to_release: got adr %h stb %b err %b exp 00000080/1/00", bus.sadr_o[0], bus.sstb_o[0], bus.merr_o); end
    bus.sack_i[0] = 1'b1;
    #1;
    checks++; if (bus.mack_o !== 2'b10) begin errors++; $display("FAIL to_release_ack: got %b exp 10", bus.mack_o); end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_concurrency();
    test_back_to_back();
    test_unmapped();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
